// File: rtl/cnn_pkg.sv
// Shared types and constants for the 5x5 filter loader and its commit handshake.
package cnn_pkg;

   localparam int K           = 5;
   localparam int TILE_WORDS  = K * K;
   localparam int NUM_FILTERS = 1920;
   localparam int NUM_BIAS    = 120;

   typedef logic signed [0:K-1][0:K-1][15:0] tile_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH_F   = 3'd1,
      ST_COMMIT_F  = 3'd2,
      ST_RELEASE_F = 3'd3,
      ST_FETCH_B   = 3'd4,
      ST_COMMIT_B  = 3'd5,
      ST_RELEASE_B = 3'd6,
      ST_DONE      = 3'd7
   } ld_state_t;

   typedef enum logic [1:0] {
      HS_IDLE    = 2'd0,
      HS_WAIT_HI = 2'd1,
      HS_WAIT_LO = 2'd2
   } hs_state_t;

   function automatic logic [10:0] clamp_filters(input logic [10:0] n);
      return (n > 11'(NUM_FILTERS)) ? 11'(NUM_FILTERS) : n;
   endfunction

   function automatic logic [6:0] clamp_bias(input logic [6:0] n);
      return (n > 7'(NUM_BIAS)) ? 7'(NUM_BIAS) : n;
   endfunction

endpackage

// File: rtl/commit_handshake.sv
// Buffer read/finish handshake: raise buf_read, wait for finish high then low,
// and give up after TIMEOUT cycles at either step.
module commit_handshake
   import cnn_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic buf_finish,
   output logic buf_read,
   output logic hi_seen,
   output logic ack,
   output logic timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   hs_state_t        hs_q, hs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             read_q, read_d;
   logic             expired_s;

   assign expired_s = (cnt_q == CNT_W'(TIMEOUT));
   assign buf_read  = read_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hs_q   <= HS_IDLE;
         cnt_q  <= '0;
         read_q <= 1'b0;
      end else begin
         hs_q   <= hs_d;
         cnt_q  <= cnt_d;
         read_q <= read_d;
      end
   end

   always_comb begin
      hs_d = hs_q;
      case (hs_q)
         HS_IDLE:    if (start) hs_d = HS_WAIT_HI; else hs_d = HS_IDLE;
         HS_WAIT_HI: if (buf_finish) hs_d = HS_WAIT_LO;
                     else if (expired_s) hs_d = HS_IDLE;
                     else hs_d = HS_WAIT_HI;
         HS_WAIT_LO: if (!buf_finish) hs_d = HS_IDLE;
                     else if (expired_s) hs_d = HS_IDLE;
                     else hs_d = HS_WAIT_LO;
         default:    hs_d = HS_IDLE;
      endcase
   end

   // buf_read is a pure function of the next state, so finish never reaches it combinationally
   always_comb begin
      hi_seen = (hs_q == HS_WAIT_HI) && buf_finish;
      ack     = (hs_q == HS_WAIT_LO) && !buf_finish;
      timeout = expired_s && (((hs_q == HS_WAIT_HI) && !buf_finish) ||
                              ((hs_q == HS_WAIT_LO) && buf_finish));
      read_d  = (hs_d == HS_WAIT_HI);
      if ((hs_d != hs_q) || (hs_q == HS_IDLE)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/filter_loader_5x5.sv
// Streams 5x5 filter tiles and the bias vector from weight memory into the
// filter buffer, committing each through the shared commit_handshake.
module filter_loader_5x5
   import cnn_pkg::*;
#(
   parameter int ADDR_W  = 20,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic [10:0]              filter_count,
   input  logic [6:0]               bias_count,
   output logic                     mem_rd,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic [15:0]              mem_data,
   output logic                     buf_read,
   output logic                     buf_bias_or_filter,
   output logic [15:0]              buf_index,
   output logic [16*TILE_WORDS-1:0] buf_filter,
   output logic [16*NUM_BIAS-1:0]   buf_bias,
   input  logic                     buf_finish,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   ld_state_t                  state_q, state_d;
   logic [10:0]                fcnt_q, fcnt_d, f_q, f_d;
   logic [6:0]                 bcnt_q, bcnt_d, issue_q, issue_d, cap_q, cap_d;
   logic [2:0]                 row_q, row_d, col_q, col_d;
   logic [ADDR_W-1:0]          addr_q, addr_d;
   logic                       rd_q, rd_d, pend_q, pend_d, bof_q, bof_d;
   logic                       busy_q, busy_d, done_q, done_d, err_q, err_d;
   tile_t                      tile_q, tile_d;
   logic [0:NUM_BIAS-1][15:0]  bias_q, bias_d;

   logic [10:0] fc_clamp_s;
   logic [6:0]  bc_clamp_s, bc_sel_s;
   logic        start_ok_s, last_f_cap_s, last_b_cap_s, last_filter_s;
   logic        enter_f_s, enter_b_s, hs_start_s, hs_hi_s, hs_ack_s, hs_to_s;

   assign fc_clamp_s    = clamp_filters(filter_count);
   assign bc_clamp_s    = clamp_bias(bias_count);
   assign start_ok_s    = (state_q == ST_IDLE) && start;
   assign bc_sel_s      = (state_q == ST_IDLE) ? bc_clamp_s : bcnt_q;
   assign last_f_cap_s  = pend_q && (cap_q == 7'(TILE_WORDS - 1));
   assign last_b_cap_s  = pend_q && (cap_q == (bcnt_q - 7'd1));
   assign last_filter_s = ((f_q + 11'd1) == fcnt_q);
   assign enter_f_s     = (state_d == ST_FETCH_F) && (state_q != ST_FETCH_F);
   assign enter_b_s     = (state_d == ST_FETCH_B) && (state_q != ST_FETCH_B);
   assign hs_start_s    = ((state_q == ST_FETCH_F) && last_f_cap_s) ||
                          ((state_q == ST_FETCH_B) && last_b_cap_s);

   commit_handshake #(.TIMEOUT(TIMEOUT)) u_commit (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (hs_start_s),
      .buf_finish (buf_finish),
      .buf_read   (buf_read),
      .hi_seen    (hs_hi_s),
      .ack        (hs_ack_s),
      .timeout    (hs_to_s)
   );

   assign mem_rd             = rd_q;
   assign mem_addr           = addr_q;
   assign buf_bias_or_filter = bof_q;
   assign buf_index          = {5'd0, f_q};
   assign buf_filter         = tile_q;
   assign buf_bias           = bias_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign error              = err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         fcnt_q  <= '0;
         bcnt_q  <= '0;
         f_q     <= '0;
         issue_q <= '0;
         cap_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         pend_q  <= 1'b0;
         bof_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         tile_q  <= '0;
         bias_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         bcnt_q  <= bcnt_d;
         f_q     <= f_d;
         issue_q <= issue_d;
         cap_q   <= cap_d;
         row_q   <= row_d;
         col_q   <= col_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         pend_q  <= pend_d;
         bof_q   <= bof_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         tile_q  <= tile_d;
         bias_q  <= bias_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:
            if (!start) state_d = ST_IDLE;
            else if ((fc_clamp_s == 11'd0) && (bc_clamp_s == 7'd0)) state_d = ST_DONE;
            else if (fc_clamp_s == 11'd0) state_d = ST_FETCH_B;
            else state_d = ST_FETCH_F;
         ST_FETCH_F:   if (last_f_cap_s) state_d = ST_COMMIT_F; else state_d = ST_FETCH_F;
         ST_COMMIT_F:  if (hs_to_s) state_d = ST_DONE;
                       else if (hs_hi_s) state_d = ST_RELEASE_F;
                       else state_d = ST_COMMIT_F;
         ST_RELEASE_F:
            if (hs_to_s) state_d = ST_DONE;
            else if (!hs_ack_s) state_d = ST_RELEASE_F;
            else if (!last_filter_s) state_d = ST_FETCH_F;
            else if (bcnt_q == 7'd0) state_d = ST_DONE;
            else state_d = ST_FETCH_B;
         ST_FETCH_B:   if (last_b_cap_s) state_d = ST_COMMIT_B; else state_d = ST_FETCH_B;
         ST_COMMIT_B:  if (hs_to_s) state_d = ST_DONE;
                       else if (hs_hi_s) state_d = ST_RELEASE_B;
                       else state_d = ST_COMMIT_B;
         ST_RELEASE_B: if (hs_to_s || hs_ack_s) state_d = ST_DONE; else state_d = ST_RELEASE_B;
         ST_DONE:      state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Reads run on one rolling address, so bias words follow the last filter word naturally
   always_comb begin
      fcnt_d = fcnt_q;
      bcnt_d = bcnt_q;
      f_d    = f_q;
      err_d  = err_q;
      addr_d = addr_q;
      tile_d = tile_q;
      bias_d = bias_q;
      pend_d = rd_q;
      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);

      if (start_ok_s) begin
         fcnt_d = fc_clamp_s;
         bcnt_d = bc_clamp_s;
         f_d    = 11'd0;
         err_d  = 1'b0;
         addr_d = base_addr;
         bias_d = '0;
      end else begin
         if ((state_q == ST_RELEASE_F) && hs_ack_s) f_d = f_q + 11'd1; else f_d = f_q;
         if (hs_to_s) err_d = 1'b1; else err_d = err_q;
         if (rd_q) addr_d = addr_q + ADDR_W'(1); else addr_d = addr_q;
         if (pend_q && (state_q == ST_FETCH_B)) bias_d[cap_q] = mem_data; else bias_d = bias_q;
      end

      if (pend_q && (state_q == ST_FETCH_F)) tile_d[row_q][col_q] = mem_data; else tile_d = tile_q;

      if (enter_f_s || enter_b_s) begin
         rd_d    = 1'b1;
         issue_d = enter_f_s ? 7'(TILE_WORDS) : bc_sel_s;
         bof_d   = enter_f_s;
         cap_d   = 7'd0;
         row_d   = 3'd0;
         col_d   = 3'd0;
      end else begin
         rd_d    = rd_q && (issue_q != 7'd1);
         issue_d = rd_q ? (issue_q - 7'd1) : issue_q;
         bof_d   = bof_q;
         cap_d   = pend_q ? (cap_q + 7'd1) : cap_q;
         if (pend_q && (col_q == 3'd4)) begin
            col_d = 3'd0;
            row_d = row_q + 3'd1;
         end else begin
            col_d = pend_q ? (col_q + 3'd1) : col_q;
            row_d = row_q;
         end
      end
   end

endmodule

// File: tb/tb_filter_loader_5x5.sv
// Scoreboard bench for filter_loader_5x5: memory returns its own address, a
// buffer model answers commits, and a monitor checks every commit and done.
module tb_filter_loader_5x5;
   import cnn_pkg::*;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                start = 1'b0;
   logic [19:0]         base_addr = 20'd0;
   logic [10:0]         filter_count = 11'd0;
   logic [6:0]          bias_count = 7'd0;
   logic                mem_rd;
   logic [19:0]         mem_addr;
   logic [15:0]         mem_data = 16'd0;
   logic                buf_read, buf_bias_or_filter;
   logic [15:0]         buf_index;
   logic [399:0]        buf_filter;
   logic [1919:0]       buf_bias;
   logic                buf_finish = 1'b0;
   logic                busy, done, error;

   typedef struct {
      logic                 bof;
      logic                 chk_idx;
      logic [15:0]          idx;
      tile_t                filt;
      logic [0:119][15:0]   bias;
   } exp_t;

   exp_t   q[$];
   logic   dq[$];
   int     errors = 0;
   int     checks = 0;
   int     done_cnt = 0;
   int     fin_delay = 0;
   logic   tie0 = 1'b0;
   logic   wrap_watch = 1'b0;
   logic   wrap_seen = 1'b0;

   filter_loader_5x5 dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .filter_count(filter_count), .bias_count(bias_count), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_data(mem_data), .buf_read(buf_read),
      .buf_bias_or_filter(buf_bias_or_filter), .buf_index(buf_index),
      .buf_filter(buf_filter), .buf_bias(buf_bias), .buf_finish(buf_finish),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Weight memory: each word holds the low 16 bits of its own address
   always @(posedge clk) begin
      if (mem_rd) mem_data <= mem_addr[15:0];
   end

   // Buffer model: raise finish fin_delay cycles after buf_read, drop it after buf_read falls
   int bcnt = 0;
   always begin
      @(posedge clk);
      #2;
      if (!reset_n) begin
         buf_finish = 1'b0;
         bcnt = 0;
      end else if (tie0) begin
         buf_finish = 1'b0;
      end else if (buf_read && !buf_finish) begin
         if (bcnt >= fin_delay) buf_finish = 1'b1;
         else bcnt++;
      end else if (!buf_read && buf_finish) begin
         buf_finish = 1'b0;
         bcnt = 0;
      end else if (!buf_read) begin
         bcnt = 0;
      end
   end

   // Monitor: pop expected commit on buf_read rise, watch stability, check each done pulse
   logic         prev_read = 1'b0, in_commit = 1'b0, viol = 1'b0;
   logic [399:0] snap_f;
   logic [1919:0] snap_b;
   logic [15:0]  snap_i;
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_read = 1'b0;
         in_commit = 1'b0;
      end else begin
         if (buf_read && !prev_read) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL commit_unexpected: got index=%0d bof=%0b, required no commit", buf_index, buf_bias_or_filter);
            end else begin
               e = q.pop_front();
               if (buf_bias_or_filter !== e.bof || (e.chk_idx && buf_index !== e.idx) ||
                   (e.bof && buf_filter !== e.filt) || (!e.bof && buf_bias !== e.bias)) begin
                  errors++;
                  if (e.bof)
                     $display("FAIL commit_filter: got bof=%0b idx=%0d tile=%h, required bof=1 idx=%0d tile=%h",
                              buf_bias_or_filter, buf_index, buf_filter, e.idx, e.filt);
                  else
                     $display("FAIL commit_bias: got bof=%0b bias[0:7]=%h, required bof=0 bias[0:7]=%h",
                              buf_bias_or_filter, buf_bias[1919:1792], e.bias[0:7]);
               end
            end
            snap_f = buf_filter;
            snap_b = buf_bias;
            snap_i = buf_index;
            in_commit = 1'b1;
            viol = 1'b0;
         end else if (in_commit) begin
            if (!buf_read && !buf_finish) begin
               in_commit = 1'b0;
               checks++;
               if (viol) begin
                  errors++;
                  $display("FAIL commit_stable: got change or mem_rd during commit idx=%0d, required stable", snap_i);
               end
            end else if (buf_filter !== snap_f || buf_bias !== snap_b || buf_index !== snap_i || mem_rd) begin
               viol = 1'b1;
            end
         end
         if (wrap_watch && mem_rd && mem_addr == 20'd0) wrap_seen = 1'b1;
         if (done) begin
            logic exp_err;
            checks++;
            done_cnt++;
            exp_err = (dq.size() != 0) ? dq.pop_front() : 1'bx;
            if (error !== exp_err || q.size() != 0 || buf_read !== 1'b0) begin
               errors++;
               $display("FAIL done_pulse: got error=%0b pending=%0d buf_read=%0b, required error=%0b pending=0 buf_read=0",
                        error, q.size(), buf_read, exp_err);
            end
         end
         prev_read = buf_read;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push_filters(input logic [19:0] base, input int fc);
      exp_t e;
      logic [19:0] a;
      for (int f = 0; f < fc; f++) begin
         e.bof = 1'b1;
         e.chk_idx = 1'b1;
         e.idx = 16'(f);
         e.bias = '0;
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
               a = base + 20'(25 * f + 5 * r + c);
               e.filt[r][c] = a[15:0];
            end
         q.push_back(e);
      end
   endtask

   task automatic push_bias(input logic [19:0] base, input int fc, input int bc);
      exp_t e;
      logic [19:0] a;
      e.bof = 1'b0;
      e.chk_idx = 1'b0;
      e.idx = 16'd0;
      e.filt = '0;
      e.bias = '0;
      for (int j = 0; j < bc; j++) begin
         a = base + 20'(25 * fc + j);
         e.bias[j] = a[15:0];
      end
      q.push_back(e);
   endtask

   task automatic start_run(input logic [19:0] base, input logic [10:0] fc, input logic [6:0] bc);
      @(negedge clk);
      base_addr = base;
      filter_count = fc;
      bias_count = bc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, input string name);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == d0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done in %0d cycles, required done", name, max_cyc);
      end
   endtask

   initial begin
      int k;
      repeat (3) @(negedge clk);
      chk("reset_read_rd_busy", {buf_read, mem_rd, busy, done, error}, 64'd0);
      chk("reset_bof", buf_bias_or_filter, 64'd1);
      chk("reset_index_addr", {buf_index, mem_addr}, 64'd0);
      chk("reset_tile_bias", {buf_filter != 400'd0, buf_bias != 1920'd0}, 64'd0);
      reset_n = 1'b1;

      // one filter, no bias, with latency checks
      push_filters(20'h00100, 1);
      dq.push_back(1'b0);
      start_run(20'h00100, 11'd1, 7'd0);
      chk("first_read", {mem_rd, busy, mem_addr}, {2'b11, 20'h00100});
      k = 1;
      while (!buf_read && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("commit_latency", 64'(k), 64'd27);
      wait_done(200, "t1");

      // three filters then four biases
      push_filters(20'h00100, 3);
      push_bias(20'h00100, 3, 4);
      dq.push_back(1'b0);
      start_run(20'h00100, 11'd3, 7'd4);
      wait_done(400, "t2");

      // bias only
      push_bias(20'h00700, 0, 2);
      dq.push_back(1'b0);
      start_run(20'h00700, 11'd0, 7'd2);
      wait_done(100, "t2b");

      // nothing to load
      dq.push_back(1'b0);
      start_run(20'h00700, 11'd0, 7'd0);
      wait_done(10, "t2c");

      // slow buffer
      fin_delay = 10;
      push_filters(20'h00500, 2);
      dq.push_back(1'b0);
      start_run(20'h00500, 11'd2, 7'd0);
      wait_done(400, "t3");
      fin_delay = 0;

      // finish never arrives
      tie0 = 1'b1;
      push_filters(20'h00200, 1);
      dq.push_back(1'b1);
      start_run(20'h00200, 11'd1, 7'd0);
      wait_done(600, "t4");
      @(negedge clk);
      chk("error_sticky", {error, buf_read, busy}, {3'b100});
      tie0 = 1'b0;
      push_filters(20'h00300, 1);
      dq.push_back(1'b0);
      start_run(20'h00300, 11'd1, 7'd0);
      chk("error_cleared", {error, busy}, 64'b01);
      wait_done(200, "t4b");

      // reset during the third filter fetch
      push_filters(20'h00400, 3);
      dq.push_back(1'b0);
      start_run(20'h00400, 11'd3, 7'd0);
      k = 0;
      while (!(mem_rd && buf_index == 16'd2) && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("reach_filter2", {mem_rd, buf_index}, {1'b1, 16'd2});
      #1 reset_n = 1'b0;
      #1;
      chk("abort_read_rd_busy", {buf_read, mem_rd, busy, done, error}, 64'd0);
      chk("abort_bof_index_addr", {buf_bias_or_filter, buf_index, mem_addr}, {1'b1, 36'd0});
      chk("abort_tile_bias", {buf_filter != 400'd0, buf_bias != 1920'd0}, 64'd0);
      q.delete();
      dq.delete();
      @(negedge clk);
      reset_n = 1'b1;
      push_filters(20'h00400, 1);
      dq.push_back(1'b0);
      start_run(20'h00400, 11'd1, 7'd0);
      wait_done(200, "t5");

      // clamp to 1920 filters with address wrap and ignored starts
      push_filters(20'hFFFF0, 1920);
      dq.push_back(1'b0);
      wrap_watch = 1'b1;
      start_run(20'hFFFF0, 11'd2000, 7'd0);
      for (int i = 0; i < 3; i++) begin
         repeat (1000) @(negedge clk);
         filter_count = 11'd5;
         base_addr = 20'h00000;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("busy_ignores_start", busy, 64'd1);
      end
      wait_done(70000, "t6");
      chk("addr_wrapped", wrap_seen, 64'd1);
      chk("queues_drained", 64'(q.size() + dq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/filter_loader_5x5.md
# filter_loader_5x5

Streams 5x5 filter weights and per-channel biases from a word-addressed weight memory into the 5x5 filter buffer. It sits directly upstream of that buffer. It assembles each 25-word tile and commits it through the buffer's read/finish handshake (bias_or_filter=1). It then commits the bias vector the same way (bias_or_filter=0) and reports done.

## Interface
- NUM_FILTERS, 1920, filter slots in the buffer
- NUM_BIAS, 120, bias slots in the buffer
- ADDR_W, 20, weight-memory address width
- TIMEOUT, 255, max cycles waiting on buf_finish edges
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- base_addr  in  ADDR_W  address of filter 0 word (0,0)
- filter_count  in  11  filters to load; values >NUM_FILTERS clamp to NUM_FILTERS
- bias_count  in  7  biases to load; values >NUM_BIAS clamp to NUM_BIAS
- mem_rd  out  1  read strobe, one word per cycle
- mem_addr  out  ADDR_W  read address
- mem_data  in  16  signed word, valid the cycle after mem_rd
- buf_read  out  1  commit strobe to buffer (level, held until finish)
- buf_bias_or_filter  out  1  1 = filter commit, 0 = bias commit
- buf_index  out  16  filter slot being committed
- buf_filter  out  16 x [5][5]  assembled tile
- buf_bias  out  16 x [120]  assembled bias vector
- buf_finish  in  1  buffer acknowledge
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on completion
- error  out  1  sticky timeout flag, cleared by next accepted start

## Operation
- Memory layout, row-major: filter f word (r,c) is at base_addr + 25f + 5r + c. Bias j is at base_addr + 25·filter_count + j. Address arithmetic is ADDR_W bits, unsigned, wraps modulo 2^ADDR_W.
- States: IDLE, FETCH_F, COMMIT_F, RELEASE_F, FETCH_B, COMMIT_B, RELEASE_B, DONE.
- IDLE: when start=1, latch the clamped counts and base, clear error, clear buf_bias to 0, set f=0. Then go to FETCH_F, or to FETCH_B if filter_count=0, or to DONE if both counts are 0.
- FETCH_F: issue 25 consecutive reads. Capture each returning word into buf_filter[r][c]. After the 25th capture, go to COMMIT_F.
- COMMIT_F: buf_read=1, buf_bias_or_filter=1, buf_index=f. Stay until buf_finish is sampled high, then go to RELEASE_F.
- RELEASE_F: buf_read=0. Stay until buf_finish is sampled low. Then f++; if f==filter_count go to FETCH_B (or DONE if bias_count=0), else go to FETCH_F.
- FETCH_B, COMMIT_B, RELEASE_B: same flow with bias_count reads into buf_bias[0..bias_count-1] and buf_bias_or_filter=0. Entries at bias_count and above stay 0.
- DONE: done=1 for one cycle, then IDLE.
- Timeout: a counter per COMMIT/RELEASE state. If it reaches TIMEOUT without the awaited buf_finish level, set error=1, drop buf_read, and go to DONE.
- start outside IDLE is ignored.

## Timing
- Reset (async assert, sync release): state IDLE. buf_read, mem_rd, busy, done, error, buf_index, mem_addr, buf_filter and buf_bias are all 0. buf_bias_or_filter is 1.
- Reset mid-operation aborts immediately. No partial commit: buf_read goes low asynchronously.
- start sampled at edge N gives mem_rd high in cycles N+1..N+25 at consecutive addresses. Words are captured at edges N+2..N+26. buf_read rises in cycle N+27.
- buf_finish is sampled registered, with no combinational path to buf_read. If it is high at edge M, buf_read is low in cycle M+1.
- Tile contents and buf_index are stable from buf_read rise until RELEASE exits.
- Per-filter cost is 25 fetch cycles, plus 1 settle cycle, plus the handshake round trip (≥4 cycles).
- done pulses in the cycle after the final RELEASE exits.

## Structure
- Shared package (cnn_pkg): tile typedef (shortint [0:4][0:4]), K=5, NUM_FILTERS, NUM_BIAS, and the loader state enum.
- One sub-module, commit_handshake: drives buf_read, waits finish high then low, implements the timeout, and returns ack or timeout. It is instantiated once and shared by the filter and bias paths.

## Test plan
- filter_count=1, bias_count=0, memory word = address, base 0x100. Tile (r,c) = 0x100+5r+c, buf_index=0, done pulses, error=0.
- filter_count=3, bias_count=4. Three commits with buf_index 0,1,2. Bias reads start at base+75. buf_bias[0..3] loaded, buf_bias[4..119]=0.
- Buffer model delays finish by 10 cycles. buf_read stays high throughout, tile stays stable, and no second fetch starts until finish returns low.
- buf_finish tied 0. After TIMEOUT cycles: error=1, buf_read=0, done pulses. The next start clears error.
- reset_n pulsed low during filter 2 fetch. All outputs return to reset values; a fresh start reloads from filter 0.
- filter_count=2000, base 0xFFFF0. Loads clamp to 1920 filters, mem_addr wraps past 0xFFFFF to 0, start pulses while busy are ignored.
